cache_nway_wb: RTL and testbench

- Parametrised N-way set-associative, write-back, write-allocate cache with true-LRU replacement.
- Successor to the fixed 2-way, 8-bit cache: way count, set count, line size and widths are all generic.
- Adds a request/ack handshake on the CPU side and on the backing-memory side, plus dirty-line eviction.
- Sits between the CPU load/store path and the main-memory controller.

---
 rtl/cache_pkg.sv | 23 ++
 rtl/cache_lru.sv | 46 ++++
 rtl/cache_nway_wb.sv | 190 +++++++++++++++++++
 tb/tb_cache_nway_wb.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared types and helpers for the parametrised write-back cache.
// Address fields are extracted generically so every configuration uses one helper.
package cache_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    WBACK,
    REFILL,
    REPLAY,
    DONE
  } cache_state_e;

  // Index width that stays at least one bit, so a single-way cache still has a legal way index.
  function automatic int log2Min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic [63:0] addrField(input logic [63:0] addr, input int lsb, input int width);
    return (addr >> lsb) & ((64'd1 << width) - 64'd1);
  endfunction

endpackage

// File: rtl/cache_lru.sv
// True-LRU age update and victim selection for one cache set.
// Age 0 is most recently used; age WAYS-1 is the replacement candidate.
module cache_lru
  import cache_pkg::*;
#(
  parameter int WAYS  = 2,
  parameter int AGE_W = 1,
  parameter int WAY_W = 1
) (
  input  logic [WAYS-1:0][AGE_W-1:0] i_ages,
  input  logic [WAYS-1:0]            i_valid,
  input  logic [WAY_W-1:0]           i_accWay,
  output logic [WAYS-1:0][AGE_W-1:0] o_newAges,
  output logic [WAY_W-1:0]           o_victim
);

  generate
    if (WAYS == 1) begin : g_direct
      assign o_newAges = '0;
      assign o_victim  = '0;
    end else begin : g_lru
      // An invalid way always wins over the oldest valid one; the lowest index is preferred.
      always_comb begin
        o_victim = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
          if (i_ages[w] == AGE_W'(WAYS - 1)) o_victim = WAY_W'(w);
        end
        for (int w = WAYS - 1; w >= 0; w--) begin
          if (!i_valid[w]) o_victim = WAY_W'(w);
        end
      end

      always_comb begin
        o_newAges = i_ages;
        for (int w = 0; w < WAYS; w++) begin
          if (WAY_W'(w) == i_accWay) begin
            o_newAges[w] = '0;
          end else if (i_ages[w] < i_ages[i_accWay]) begin
            o_newAges[w] = i_ages[w] + 1'b1;
          end
        end
      end
    end
  endgenerate

endmodule

// File: rtl/cache_nway_wb.sv
// N-way set-associative write-back, write-allocate cache with true-LRU replacement,
// a CPU request/ready handshake and a line-wide memory request/ack handshake.
module cache_nway_wb
  import cache_pkg::*;
#(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 8,
  parameter int WAYS       = 2,
  parameter int SETS       = 8,
  parameter int LINE_WORDS = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cpu_req,
  input  logic                         cpu_we,
  input  logic [ADDR_W-1:0]            address_bus,
  input  logic [DATA_W-1:0]            data_in,
  output logic [DATA_W-1:0]            data_out,
  output logic                         cpu_ready,
  output logic                         cache_hit,
  output logic                         cache_miss,
  output logic                         mem_req,
  output logic                         mem_we,
  output logic [ADDR_W-1:0]            mem_addr,
  output logic [DATA_W*LINE_WORDS-1:0] mem_wdata,
  input  logic [DATA_W*LINE_WORDS-1:0] mem_rdata,
  input  logic                         mem_ack
);

  localparam int IDX_W  = $clog2(SETS);
  localparam int OFF_W  = $clog2(LINE_WORDS);
  localparam int TAG_W  = ADDR_W - IDX_W - OFF_W;
  localparam int LINE_W = DATA_W * LINE_WORDS;
  localparam int WAY_W  = log2Min1(WAYS);
  localparam int AGE_W  = WAY_W;

  cache_state_e r_state, w_nextState;

  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_dataOut;
  logic              r_we;
  logic [WAY_W-1:0]  r_victim;

  logic [WAYS-1:0]            r_valid [SETS];
  logic [WAYS-1:0]            r_dirty [SETS];
  logic [WAYS-1:0][AGE_W-1:0] r_age   [SETS];
  logic [TAG_W-1:0]           r_tag   [SETS][WAYS];
  logic [LINE_W-1:0]          r_data  [SETS][WAYS];

  logic [TAG_W-1:0]           w_tag;
  logic [IDX_W-1:0]           w_idx;
  logic [OFF_W-1:0]           w_off;
  logic                       w_hit;
  logic [WAY_W-1:0]           w_hitWay;
  logic [WAY_W-1:0]           w_accWay;
  logic                       w_access;
  logic [WAYS-1:0][AGE_W-1:0] w_newAges;
  logic [WAY_W-1:0]           w_victim;

  assign w_off = OFF_W'(addrField(64'(r_addr), 0, OFF_W));
  assign w_idx = IDX_W'(addrField(64'(r_addr), OFF_W, IDX_W));
  assign w_tag = TAG_W'(addrField(64'(r_addr), OFF_W + IDX_W, TAG_W));

  always_comb begin
    w_hit    = 1'b0;
    w_hitWay = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (r_valid[w_idx][w] && (r_tag[w_idx][w] == w_tag)) begin
        w_hit    = 1'b1;
        w_hitWay = WAY_W'(w);
      end
    end
  end

  // REPLAY repeats the hit path on the way that was just refilled.
  assign w_accWay = (r_state == REPLAY) ? r_victim : w_hitWay;
  assign w_access = ((r_state == LOOKUP) && w_hit) || (r_state == REPLAY);

  cache_lru #(
    .WAYS  (WAYS),
    .AGE_W (AGE_W),
    .WAY_W (WAY_W)
  ) u_lru (
    .i_ages    (r_age[w_idx]),
    .i_valid   (r_valid[w_idx]),
    .i_accWay  (w_accWay),
    .o_newAges (w_newAges),
    .o_victim  (w_victim)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:   if (cpu_req) w_nextState = LOOKUP;
      LOOKUP: begin
        if (w_hit)                                                w_nextState = DONE;
        else if (r_valid[w_idx][w_victim] && r_dirty[w_idx][w_victim]) w_nextState = WBACK;
        else                                                      w_nextState = REFILL;
      end
      WBACK:  if (mem_ack) w_nextState = REFILL;
      REFILL: if (mem_ack) w_nextState = REPLAY;
      REPLAY: w_nextState = DONE;
      DONE:   w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  always_comb begin
    cpu_ready  = (r_state == DONE);
    cache_hit  = 1'b0;
    cache_miss = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    case (r_state)
      LOOKUP: begin
        cache_hit  = w_hit;
        cache_miss = !w_hit;
      end
      WBACK: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {r_tag[w_idx][r_victim], w_idx, {OFF_W{1'b0}}};
        mem_wdata = r_data[w_idx][r_victim];
      end
      REFILL: begin
        mem_req  = 1'b1;
        mem_addr = {w_tag, w_idx, {OFF_W{1'b0}}};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr    <= '0;
      r_wdata   <= '0;
      r_we      <= 1'b0;
      r_victim  <= '0;
      r_dataOut <= '0;
      for (int s = 0; s < SETS; s++) begin
        r_valid[s] <= '0;
        r_dirty[s] <= '0;
        for (int w = 0; w < WAYS; w++) r_age[s][w] <= AGE_W'(w);
      end
    end else begin
      case (r_state)
        IDLE: begin
          if (cpu_req) begin
            r_addr  <= address_bus;
            r_wdata <= data_in;
            r_we    <= cpu_we;
          end
        end
        LOOKUP: if (!w_hit) r_victim <= w_victim;
        REFILL: begin
          if (mem_ack) begin
            r_valid[w_idx][r_victim] <= 1'b1;
            r_dirty[w_idx][r_victim] <= 1'b0;
          end
        end
        default: ;
      endcase
      if (w_access) begin
        r_age[w_idx] <= w_newAges;
        if (r_we) r_dirty[w_idx][w_accWay] <= 1'b1;
        else      r_dataOut <= r_data[w_idx][w_accWay][w_off*DATA_W +: DATA_W];
      end
    end
  end

  // Tags and line data carry no reset; the valid bits alone decide whether they mean anything.
  always_ff @(posedge clk) begin
    if ((r_state == REFILL) && mem_ack) begin
      r_data[w_idx][r_victim] <= mem_rdata;
      r_tag[w_idx][r_victim]  <= w_tag;
    end
    if (w_access && r_we) r_data[w_idx][w_accWay][w_off*DATA_W +: DATA_W] <= r_wdata;
  end

  assign data_out = r_dataOut;

endmodule

// File: tb/tb_cache_nway_wb.sv
// Table-driven bench for cache_nway_wb (2 ways, 8 sets, 2-word lines) with a
// flat-memory reference, a latency-modelled memory responder and a scoreboard queue.
module tb_cache_nway_wb;

  localparam int MEM_LAT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req;
  logic        cpu_we;
  logic [15:0] address_bus;
  logic [7:0]  data_in;
  logic [7:0]  data_out;
  logic        cpu_ready;
  logic        cache_hit;
  logic        cache_miss;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_ack;

  cache_nway_wb #(
    .ADDR_W     (16),
    .DATA_W     (8),
    .WAYS       (2),
    .SETS       (8),
    .LINE_WORDS (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cpu_req     (cpu_req),
    .cpu_we      (cpu_we),
    .address_bus (address_bus),
    .data_in     (data_in),
    .data_out    (data_out),
    .cpu_ready   (cpu_ready),
    .cache_hit   (cache_hit),
    .cache_miss  (cache_miss),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .mem_ack     (mem_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] addr;
    logic        we;
    logic [7:0]  wdata;
    logic        expHit;
    int          expWb;
    int          expCycles;
  } vec_t;

  typedef struct {
    logic        we;
    logic [7:0]  data;
    logic        hit;
  } exp_t;

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [15:0] data;
  } memEv_t;

  vec_t        vecs[$];
  exp_t        sbQueue[$];
  memEv_t      memLog[$];
  logic [15:0] memModel [logic [15:0]];
  logic [7:0]  cpuView  [logic [15:0]];

  int checks = 0;
  int errors = 0;
  int memWait = 0;
  bit memHold = 1'b0;

  function automatic logic [15:0] memInit(input logic [15:0] la);
    if (la == 16'hF0F0) return 16'hABCD;
    return {la[7:0] ^ 8'h5A, la[15:8] ^ 8'hC3};
  endfunction

  function automatic logic [15:0] memRead(input logic [15:0] la);
    if (memModel.exists(la)) return memModel[la];
    return memInit(la);
  endfunction

  function automatic logic [7:0] expByte(input logic [15:0] a);
    logic [15:0] line;
    if (cpuView.exists(a)) return cpuView[a];
    line = memRead({a[15:1], 1'b0});
    return a[0] ? line[15:8] : line[7:0];
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic addVec(input logic [15:0] a, input logic we, input logic [7:0] d,
                        input logic h, input int wb, input int cyc);
    vec_t v;
    v.addr = a; v.we = we; v.wdata = d; v.expHit = h; v.expWb = wb; v.expCycles = cyc;
    vecs.push_back(v);
  endtask

  // Memory responder: acks MEM_LAT+1 negedges after a request becomes visible.
  initial begin
    mem_ack   = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      mem_ack = 1'b0;
      if (mem_req && !rst && !memHold) begin
        if (memWait == MEM_LAT) begin
          memWait = 0;
          mem_ack = 1'b1;
          if (mem_we) begin
            memModel[mem_addr] = mem_wdata;
            memLog.push_back('{1'b1, mem_addr, mem_wdata});
          end else begin
            mem_rdata = memRead(mem_addr);
            memLog.push_back('{1'b0, mem_addr, mem_rdata});
          end
        end else begin
          memWait++;
        end
      end else begin
        memWait = 0;
      end
    end
  end

  task automatic applyStimulus(input vec_t v, input int idx);
    exp_t e;
    int   cycles = 0;
    int   hits = 0;
    int   misses = 0;
    int   logStart;
    int   wbs = 0;
    int   refills = 0;
    bit   ready = 1'b0;
    @(negedge clk);
    cpu_req     = 1'b1;
    cpu_we      = v.we;
    address_bus = v.addr;
    data_in     = v.wdata;
    e.we   = v.we;
    e.hit  = v.expHit;
    e.data = v.we ? v.wdata : expByte(v.addr);
    if (v.we) cpuView[v.addr] = v.wdata;
    sbQueue.push_back(e);
    logStart = memLog.size();
    while (!ready && cycles < 200) begin
      @(negedge clk);
      cycles++;
      hits   += int'(cache_hit);
      misses += int'(cache_miss);
      if (cpu_ready) ready = 1'b1;
    end
    cpu_req = 1'b0;
    if (!ready) begin
      checkOutput($sformatf("vec%0d cpu_ready timeout", idx), 64'd0, 64'd1);
      sbQueue.delete();
      return;
    end
    if (sbQueue.size() == 0) begin
      checkOutput($sformatf("vec%0d scoreboard empty", idx), 64'd0, 64'd1);
      return;
    end
    e = sbQueue.pop_front();
    if (!e.we) checkOutput($sformatf("vec%0d data_out", idx), 64'(data_out), 64'(e.data));
    checkOutput($sformatf("vec%0d cache_hit pulses", idx), 64'(hits), 64'(e.hit));
    checkOutput($sformatf("vec%0d cache_miss pulses", idx), 64'(misses), 64'(!e.hit));
    checkOutput($sformatf("vec%0d latency", idx), 64'(cycles), 64'(v.expCycles));
    for (int i = logStart; i < memLog.size(); i++) begin
      if (memLog[i].we) wbs++;
      else              refills++;
    end
    checkOutput($sformatf("vec%0d writebacks", idx), 64'(wbs), 64'(v.expWb));
    checkOutput($sformatf("vec%0d refills", idx), 64'(refills), v.expHit ? 64'd0 : 64'd1);
  endtask

  task automatic resetMidRefill();
    int waitCycles = 0;
    @(negedge clk);
    memHold     = 1'b1;
    cpu_req     = 1'b1;
    cpu_we      = 1'b0;
    address_bus = 16'h2220;
    while (!mem_req && waitCycles < 20) begin
      @(negedge clk);
      waitCycles++;
    end
    checkOutput("rst-test mem_req raised", 64'(mem_req), 64'd1);
    checkOutput("rst-test mem_we", 64'(mem_we), 64'd0);
    checkOutput("rst-test mem_addr", 64'(mem_addr), 64'h2220);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("rst-test mem_req dropped", 64'(mem_req), 64'd0);
    checkOutput("rst-test cpu_ready", 64'(cpu_ready), 64'd0);
    rst     = 1'b0;
    cpu_req = 1'b0;
    memHold = 1'b0;
    cpuView.delete();
  endtask

  initial begin
    int n;
    rst = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; address_bus = '0; data_in = '0;

    // addr, we, wdata, hit, writebacks, cycles (hit 2, clean miss 6, dirty miss 9)
    addVec(16'hF0F1, 0, 8'h00, 0, 0, 6);
    addVec(16'hF0F1, 0, 8'h00, 1, 0, 2);
    addVec(16'hF0F0, 0, 8'h00, 1, 0, 2);
    addVec(16'h1230, 0, 8'h00, 0, 0, 6);
    addVec(16'hF0F1, 0, 8'h00, 1, 0, 2);
    addVec(16'h4560, 0, 8'h00, 0, 0, 6);
    addVec(16'hF0F1, 0, 8'h00, 1, 0, 2);
    addVec(16'h1230, 0, 8'h00, 0, 0, 6);
    addVec(16'h4560, 0, 8'h00, 0, 0, 6);
    addVec(16'hF0F1, 0, 8'h00, 0, 0, 6);
    addVec(16'h5657, 1, 8'hAB, 0, 0, 6);
    addVec(16'h5657, 0, 8'h00, 1, 0, 2);
    addVec(16'h5656, 0, 8'h00, 1, 0, 2);
    addVec(16'h7776, 0, 8'h00, 0, 0, 6);
    addVec(16'h8886, 0, 8'h00, 0, 1, 9);
    addVec(16'h5657, 0, 8'h00, 0, 0, 6);
    addVec(16'h5656, 1, 8'h3C, 1, 0, 2);
    addVec(16'h5656, 0, 8'h00, 1, 0, 2);
    addVec(16'hF0F1, 0, 8'h00, 0, 0, 6);
    addVec(16'h5656, 0, 8'h00, 0, 0, 6);
    addVec(16'hF0F1, 0, 8'h00, 1, 0, 2);

    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset data_out", 64'(data_out), 64'd0);
    checkOutput("reset cpu_ready", 64'(cpu_ready), 64'd0);
    checkOutput("reset cache_hit", 64'(cache_hit), 64'd0);
    checkOutput("reset cache_miss", 64'(cache_miss), 64'd0);
    checkOutput("reset mem_req", 64'(mem_req), 64'd0);
    checkOutput("reset mem_we", 64'(mem_we), 64'd0);
    checkOutput("reset mem_addr", 64'(mem_addr), 64'd0);
    checkOutput("reset mem_wdata", 64'(mem_wdata), 64'd0);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      if (i == 18) resetMidRefill();
      n = memLog.size();
      applyStimulus(vecs[i], i);
      if (i == 0) begin
        if (memLog.size() > n) checkOutput("first refill addr", 64'(memLog[n].addr), 64'hF0F0);
        else                   checkOutput("first refill present", 64'd0, 64'd1);
      end
      if (i == 14) begin
        if (memLog.size() >= n + 2) begin
          checkOutput("evict first is wback", 64'(memLog[n].we), 64'd1);
          checkOutput("evict wback addr", 64'(memLog[n].addr), 64'h5656);
          checkOutput("evict wback lane1", 64'(memLog[n].data[15:8]), 64'hAB);
          checkOutput("evict then refill", 64'(memLog[n+1].we), 64'd0);
          checkOutput("evict refill addr", 64'(memLog[n+1].addr), 64'h8886);
        end else begin
          checkOutput("evict transactions present", 64'(memLog.size() - n), 64'd2);
        end
      end
    end

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
